// File: rtl/frame_dump_tx_if.sv
// Byte-stream and RAM read-port bundle between frame_dump_tx and its sink / frame buffer.
interface frame_dump_tx_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
);
  logic              start;
  logic              rd_rqst;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, ram_rdata, tx_ready,
    output rd_rqst, ram_addr, tx_data, tx_valid, tx_last, busy, done
  );

  modport slave (
    output start, ram_rdata, tx_ready,
    input  rd_rqst, ram_addr, tx_data, tx_valid, tx_last, busy, done
  );
endinterface

// File: rtl/frame_dump_tx.sv
// Streams each frame-buffer row out MSB byte first; first byte 3 cycles after start,
// 10 cycles per row when unstalled; holds tx_data/tx_valid in SEND while tx_ready is low.
module frame_dump_tx #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 64,
  parameter int NUM_ROWS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_dump_tx_if.master      bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;

  logic                rd_rqst_c;
  logic                tx_valid_c;
  logic                busy_c;
  logic                done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rd_rqst_c  = 1'b0;
    tx_valid_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          row_d   = '0;
        end
      end

      S_FETCH: begin
        rd_rqst_c = 1'b1;
        busy_c    = 1'b1;
        state_d   = S_LATCH;
      end

      // RAM data for row_q is valid here, one cycle after the address settled.
      S_LATCH: begin
        rd_rqst_c  = 1'b1;
        busy_c     = 1'b1;
        shift_d    = bus.ram_rdata;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        busy_c     = 1'b1;
        tx_valid_c = 1'b1;
        if (bus.tx_ready) begin
          shift_d = shift_q << 8;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        row_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address comes straight from the row counter, so it holds through SEND.
  assign bus.ram_addr = row_q;
  assign bus.rd_rqst  = rd_rqst_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = (state_q == S_SEND) ? shift_q[DATA_W-1 -: 8] : 8'h00;
  assign bus.tx_last  = (state_q == S_SEND) && (row_q == LAST_ROW) &&
                        (byte_cnt_q == LAST_BYTE);
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

endmodule

// File: tb/tb_frame_dump_tx.sv
// Directed bench for frame_dump_tx: a default 128-row instance and a single-row instance.
module tb_frame_dump_tx;

  logic clk;
  logic rst;

  frame_dump_tx_if #(.ADDR_W(7), .DATA_W(64)) b0 ();
  frame_dump_tx_if #(.ADDR_W(7), .DATA_W(64)) b1 ();

  frame_dump_tx #(.ADDR_W(7), .DATA_W(64), .NUM_ROWS(128)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  frame_dump_tx #(.ADDR_W(7), .DATA_W(64), .NUM_ROWS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffers: row r of dut0 holds {8{r}}.
  always @(posedge clk) b0.ram_rdata <= {8{8'(b0.ram_addr)}};
  always @(posedge clk) b1.ram_rdata <= (b1.ram_addr == 7'd0) ? 64'h0123_4567_89AB_CDEF
                                                              : 64'hDEAD_BEEF_DEAD_BEEF;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor on dut0, sampling mid-cycle.
  logic       mon_clr = 1'b0;
  int         n_bytes, n_dbad, n_last, last_idx, n_stab, n_rd, n_fetch, n_abad, n_done;
  logic       stall_q, rd_prev;
  logic [7:0] held;

  always begin
    @(negedge clk); #1;
    if (mon_clr || rst) begin
      if (mon_clr) begin
        n_bytes = 0; n_dbad = 0; n_last = 0; last_idx = -1; n_stab = 0;
        n_rd = 0; n_fetch = 0; n_abad = 0; n_done = 0;
      end
      stall_q = 1'b0;
      rd_prev = 1'b0;
    end else begin
      if (stall_q && (b0.tx_valid !== 1'b1 || b0.tx_data !== held)) n_stab++;
      if (b0.tx_valid && b0.tx_ready) begin
        if (b0.tx_data !== 8'(n_bytes / 8)) n_dbad++;
        if (b0.tx_last) begin
          n_last++;
          last_idx = n_bytes;
        end
        n_bytes++;
      end
      stall_q = b0.tx_valid && !b0.tx_ready;
      held    = b0.tx_data;
      if (b0.rd_rqst) begin
        n_rd++;
        if (!rd_prev) begin
          if (b0.ram_addr !== 7'(n_fetch)) n_abad++;
          n_fetch++;
        end else if (b0.ram_addr !== 7'(n_fetch - 1)) begin
          n_abad++;
        end
      end
      rd_prev = b0.rd_rqst;
      if (b0.done) n_done++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a dut0 frame with tx_ready high; returns the cycle of the done pulse (-1 on timeout).
  task automatic run_frame(output int dc, output int first_v);
    dc          = -1;
    first_v     = -1;
    mon_clr     = 1'b1;
    b0.tx_ready = 1'b1;
    b0.start    = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      tick;
      if (c == 1) begin
        mon_clr  = 1'b0;
        b0.start = 1'b0;
      end
      if (b0.tx_valid && first_v < 0) first_v = c;
      if (b0.done) begin
        dc = c;
        break;
      end
    end
    tick;
  endtask

  logic [7:0] row0_bytes [8];
  int         done_cyc, first_v, busy_low, found;

  initial begin
    row0_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    rst = 1'b1;
    b0.start = 1'b0; b0.tx_ready = 1'b0;
    b1.start = 1'b0; b1.tx_ready = 1'b0;
    repeat (3) tick;

    chk("reset_outputs_dut0", 64'({b0.rd_rqst, b0.busy, b0.done, b0.tx_valid, b0.tx_last,
                                   b0.tx_data, b0.ram_addr}), 64'd0);
    chk("reset_outputs_dut1", 64'({b1.rd_rqst, b1.busy, b1.done, b1.tx_valid, b1.tx_last,
                                   b1.tx_data, b1.ram_addr}), 64'd0);

    // Idle with tx_ready high and no start must stay quiet.
    rst = 1'b0;
    b0.tx_ready = 1'b1;
    repeat (4) tick;
    chk("idle_no_valid", 64'(b0.tx_valid), 64'd0);
    chk("idle_no_busy", 64'({b0.busy, b0.rd_rqst}), 64'd0);

    // Single-row frame on dut1.
    b1.tx_ready = 1'b1;
    b1.start    = 1'b1;
    chk("row1_c0_busy", 64'(b1.busy), 64'd0);
    tick;
    b1.start = 1'b0;
    chk("row1_c1_rd_rqst", 64'(b1.rd_rqst), 64'd1);
    chk("row1_c1_addr", 64'(b1.ram_addr), 64'd0);
    chk("row1_c1_valid", 64'(b1.tx_valid), 64'd0);
    tick;
    chk("row1_c2_rd_rqst", 64'(b1.rd_rqst), 64'd1);
    chk("row1_c2_valid", 64'(b1.tx_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("row1_byte_valid", 64'(b1.tx_valid), 64'd1);
      chk("row1_byte_data", 64'(b1.tx_data), 64'(row0_bytes[i]));
      chk("row1_byte_last", 64'(b1.tx_last), (i == 7) ? 64'd1 : 64'd0);
      chk("row1_byte_rd_rqst", 64'(b1.rd_rqst), 64'd0);
    end
    tick;
    chk("row1_c11_done", 64'(b1.done), 64'd1);
    chk("row1_c11_valid", 64'(b1.tx_valid), 64'd0);
    tick;
    chk("row1_c12_done", 64'(b1.done), 64'd0);

    // Full default frame, tx_ready tied high.
    run_frame(done_cyc, first_v);
    chk("frame_first_valid_cycle", 64'(first_v), 64'd3);
    chk("frame_done_cycle", 64'(done_cyc), 64'd1281);
    chk("frame_rd_rqst_cycles", 64'(n_rd), 64'd256);
    chk("frame_fetches", 64'(n_fetch), 64'd128);
    chk("frame_addr_walk_errs", 64'(n_abad), 64'd0);
    chk("frame_bytes", 64'(n_bytes), 64'd1024);
    chk("frame_data_errs", 64'(n_dbad), 64'd0);
    chk("frame_last_count", 64'(n_last), 64'd1);
    chk("frame_last_index", 64'(last_idx), 64'd1023);
    chk("frame_done_count", 64'(n_done), 64'd1);

    // Random backpressure, with start pulses while busy at cycles 5 and 40.
    done_cyc = -1;
    busy_low = 0;
    mon_clr  = 1'b1;
    b0.start = 1'b1;
    for (int c = 1; c <= 8000; c++) begin
      tick;
      mon_clr     = 1'b0;
      b0.start    = (c == 5 || c == 40);
      b0.tx_ready = 1'($urandom_range(0, 1));
      if (b0.done) begin
        done_cyc = c;
        break;
      end
      if (!b0.busy) busy_low++;
    end
    b0.start    = 1'b0;
    b0.tx_ready = 1'b1;
    repeat (30) tick;
    chk("bp_done_seen", 64'(done_cyc > 0), 64'd1);
    chk("bp_busy_low_cycles", 64'(busy_low), 64'd0);
    chk("bp_bytes", 64'(n_bytes), 64'd1024);
    chk("bp_data_errs", 64'(n_dbad), 64'd0);
    chk("bp_stability_errs", 64'(n_stab), 64'd0);
    chk("bp_last_count", 64'(n_last), 64'd1);
    chk("bp_done_count", 64'(n_done), 64'd1);
    chk("bp_no_restart", 64'({b0.busy, b0.tx_valid}), 64'd0);

    // Stall then reset in the middle of row 60, byte 3.
    found       = 0;
    mon_clr     = 1'b1;
    b0.tx_ready = 1'b1;
    b0.start    = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      tick;
      if (c == 1) begin
        mon_clr  = 1'b0;
        b0.start = 1'b0;
      end
      if (n_bytes == 483) begin
        found = 1;
        break;
      end
    end
    b0.tx_ready = 1'b0;
    chk("mid_reached", 64'(found), 64'd1);
    chk("mid_addr", 64'(b0.ram_addr), 64'd60);
    chk("mid_data", 64'(b0.tx_data), 64'h3C);
    repeat (10) tick;
    chk("stall_valid_data", 64'({b0.tx_valid, b0.tx_data}), 64'h13C);
    chk("stall_no_accept", 64'(n_bytes), 64'd483);
    chk("stall_stability_errs", 64'(n_stab), 64'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({b0.rd_rqst, b0.busy, b0.done, b0.tx_valid, b0.tx_last,
                                    b0.tx_data, b0.ram_addr}), 64'd0);
    repeat (3) tick;
    chk("held_reset_outputs", 64'({b0.rd_rqst, b0.busy, b0.done, b0.tx_valid, b0.tx_last,
                                   b0.tx_data, b0.ram_addr}), 64'd0);
    rst = 1'b0;
    b0.tx_ready = 1'b1;
    repeat (5) tick;
    chk("post_reset_idle", 64'({b0.busy, b0.tx_valid, b0.rd_rqst}), 64'd0);

    run_frame(done_cyc, first_v);
    chk("restart_done_cycle", 64'(done_cyc), 64'd1281);
    chk("restart_addr_walk_errs", 64'(n_abad), 64'd0);
    chk("restart_fetches", 64'(n_fetch), 64'd128);
    chk("restart_bytes", 64'(n_bytes), 64'd1024);
    chk("restart_data_errs", 64'(n_dbad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_dump_tx.md
Name: frame_dump_tx

Overview:
- Reads the filtered image back out of the frame-buffer RAM, one 64-bit row at a time, after the image filter has written it.
- Serialises each row into 8 bytes on a valid/ready byte stream, for a UART or debug-capture sink.
- It is the read-side counterpart of the filter's RAM write port.
- It raises rd_rqst while it owns the RAM read address, so the top level can mux its address against the VGA address.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 64, RAM word width (one image row); must be a multiple of 8.
- NUM_ROWS, 128, rows per frame; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to dump a frame; sampled only in IDLE.
- rd_rqst  out  1  high while this block drives ram_addr (FETCH, LATCH).
- ram_addr  out  ADDR_W  RAM read address.
- ram_rdata  in  DATA_W  RAM read data; valid by the cycle after ram_addr is stable.
- tx_data  out  8  byte to sink.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a rising edge.
- tx_last  out  1  high with the final byte of the frame.
- busy  out  1  high in FETCH, LATCH and SEND.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE, row=0, byte_cnt=0, shift_reg=0.
  - All outputs 0: rd_rqst, ram_addr, tx_data, tx_valid, tx_last, busy, done.
- States: IDLE, FETCH, LATCH, SEND, DONE.
- IDLE:
  - start=1 -> FETCH, row=0.
  - start=0 -> stay in IDLE.
- FETCH (1 cycle):
  - ram_addr=row, rd_rqst=1.
  - Next state LATCH.
- LATCH (1 cycle):
  - ram_addr=row held, rd_rqst=1.
  - shift_reg<=ram_rdata at the end of the cycle; byte_cnt<=0.
  - Next state SEND.
- SEND:
  - rd_rqst=0; ram_addr holds its last value.
  - tx_valid=1, tx_data=shift_reg[DATA_W-1:DATA_W-8]: MSB byte first, so pixel column 0 is in bit 7 of the first byte.
  - tx_data and tx_valid stay stable until the byte is accepted.
  - On accept: shift_reg<<=8, byte_cnt++.
  - Accept of byte DATA_W/8-1 with row<NUM_ROWS-1: row++, go to FETCH.
  - Accept of byte DATA_W/8-1 with row=NUM_ROWS-1: go to DONE.
- tx_last=1 exactly when state=SEND, row=NUM_ROWS-1 and byte_cnt=DATA_W/8-1.
- DONE (1 cycle):
  - done=1, tx_valid=0, row<=0.
  - Next state IDLE.
- busy=1 in FETCH, LATCH and SEND only.
- Latency and throughput:
  - tx_valid first rises 3 cycles after the cycle in which start is sampled.
  - With tx_ready tied high: 10 cycles per row, 1280 cycles per default frame, then the done pulse.
- Boundary conditions:
  - start outside IDLE is ignored; it is not queued.
  - tx_ready while tx_valid=0 has no effect.
  - tx_ready held low stalls indefinitely in SEND with no data loss.
  - row counter never wraps mid-frame; it is cleared in DONE.
  - Reset mid-frame aborts immediately; the next frame needs a new start and begins at row 0.
  - ram_rdata is ignored outside LATCH.

Test Plan:
- Reset check: assert rst for 3 cycles mid-SEND -> all outputs 0 immediately; after release the block stays in IDLE with no tx_valid until start.
- Single row: NUM_ROWS=1, row0=64'h0123_4567_89AB_CDEF, tx_ready=1, start pulse at cycle 0.
  - Expect rd_rqst=1 at cycles 1-2 with ram_addr=0.
  - Expect bytes 01,23,45,67,89,AB,CD,EF at cycles 3-10, tx_last only on EF.
  - Expect done pulse at cycle 11.
- Backpressure: random tx_ready (50%) over a full default frame with row r = {8{r[7:0]}} -> exactly 1024 bytes, each row r sent as 8 copies of r, tx_data stable whenever tx_valid && !tx_ready, a single tx_last, a single done.
- Start while busy: pulse start at cycles 5 and 40 of a frame -> exactly one frame emitted; busy stays high through the frame with no restart.
- Full-frame timing: tx_ready=1, default parameters -> done 1281 cycles after the start-sample cycle; ram_addr walks 0..127; rd_rqst asserted for exactly 256 cycles.
- Reset mid-frame then restart: rst at row 60, byte 3; release, then pulse start -> output restarts from row 0, byte 0.
